// File: rtl/handshake_pkg.sv
// -----------------------------------------------------------------------------
// handshake_pkg
//
// Shared definitions for the valid/ready skid buffer.
//   DEFAULT_DATA_W  - default payload width
//   state_t         - buffer FSM state. The encoding is the number of held
//                     entries, so occupancy is the state code itself.
//   state_occupancy - maps a state to its 2-bit occupancy count
// -----------------------------------------------------------------------------
package handshake_pkg;

    localparam int DEFAULT_DATA_W = 8;

    // Code 2'd3 is never produced by any transition.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    function automatic logic [1:0] state_occupancy(input state_t s);
        return s;
    endfunction

endpackage : handshake_pkg

// File: rtl/handshake_skid_buffer.sv
// -----------------------------------------------------------------------------
// handshake_skid_buffer
//
// Two-entry valid/ready skid buffer. It breaks every combinational path
// between the pre-stage and the post-stage while still sustaining one
// transfer per cycle. The main register feeds the post-stage. The skid
// register catches the one word that arrives in the cycle the post-stage
// stalls. ready_pre_o was already 1 in that cycle, so the word cannot be
// refused.
//
// Parameters
//   DATA_W        payload width in bits
//
// Ports
//   clk           single clock, rising edge
//   rst           synchronous, active-high reset
//   valid_pre_i   payload valid from pre-stage
//   data_pre_i    payload from pre-stage
//   ready_pre_o   accept indication to pre-stage (flop output)
//   valid_post_o  payload valid to post-stage (flop output)
//   data_post_o   payload to post-stage (flop output, main register)
//   ready_post_i  accept indication from post-stage
//   occupancy_o   number of held entries: 0, 1 or 2
// -----------------------------------------------------------------------------
module handshake_skid_buffer
    import handshake_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_pre_i,
    input  logic [DATA_W-1:0] data_pre_i,
    output logic              ready_pre_o,
    output logic              valid_post_o,
    output logic [DATA_W-1:0] data_post_o,
    input  logic              ready_post_i,
    output logic [1:0]        occupancy_o
);

    state_t            state;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              ready_q;
    logic              valid_q;

    // Transfer qualifiers. Each one combines an input with a local flop. These
    // qualifiers only steer state updates. No output is derived from them
    // combinationally.
    logic ingress;
    logic egress;

    assign ingress = valid_pre_i & ready_q;
    assign egress  = valid_q & ready_post_i;

    // -------------------------------------------------------------------------
    // FSM with registered handshake outputs.
    //
    // ready_q and valid_q are loaded together with the next state. Each one
    // always equals the flag implied by the state it accompanies:
    //   ready = (state != FULL)
    //   valid = (state != EMPTY)
    // This keeps both outputs on flops with no decode logic behind them.
    // -------------------------------------------------------------------------
    // NOTE: every assignment to state here uses <=. All flops then update
    // from the same pre-edge values, and a later statement cannot observe an
    // earlier statement's new value within the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the payload registers are reset as well as the control
            // state. data_post_o must read 0 after reset, and any entries
            // held at reset must never be replayed.
            state   <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (ingress) begin
                        main_q  <= data_pre_i;
                        state   <= BUSY;
                        ready_q <= 1'b1;
                        valid_q <= 1'b1;
                    end
                end

                BUSY: begin
                    case ({ingress, egress})
                        2'b10: begin
                            // Post-stage stalled while a new word arrived.
                            // Park the new word in skid and stop accepting.
                            skid_q  <= data_pre_i;
                            state   <= FULL;
                            ready_q <= 1'b0;
                            valid_q <= 1'b1;
                        end
                        2'b01: begin
                            state   <= EMPTY;
                            ready_q <= 1'b1;
                            valid_q <= 1'b0;
                        end
                        2'b11: begin
                            // Pass-through: main drains and refills in the
                            // same edge.
                            main_q  <= data_pre_i;
                            state   <= BUSY;
                            ready_q <= 1'b1;
                            valid_q <= 1'b1;
                        end
                        default: begin
                            // Nothing moved. Hold state and main.
                        end
                    endcase
                end

                FULL: begin
                    // ingress cannot happen here because ready_q is 0.
                    if (egress) begin
                        main_q  <= skid_q;
                        state   <= BUSY;
                        ready_q <= 1'b1;
                        valid_q <= 1'b1;
                    end
                end

                default: begin
                    // Unreachable code 2'd3. Fall back to a clean empty buffer.
                    state   <= EMPTY;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready_pre_o  = ready_q;
    assign valid_post_o = valid_q;
    assign data_post_o  = main_q;
    assign occupancy_o  = state_occupancy(state);

    // -------------------------------------------------------------------------
    // Structural invariants of the encoding.
    // -------------------------------------------------------------------------
    a_occ_legal : assert property (@(posedge clk) disable iff (rst)
        occupancy_o != 2'd3);

    a_ready_matches_state : assert property (@(posedge clk) disable iff (rst)
        ready_q == (state != FULL));

    a_valid_matches_state : assert property (@(posedge clk) disable iff (rst)
        valid_q == (state != EMPTY));

endmodule : handshake_skid_buffer

// File: tb/tb_handshake_skid_buffer.sv
// -----------------------------------------------------------------------------
// tb_handshake_skid_buffer
//
// The reference model is a FIFO of capacity two kept as a queue:
//   ready = size < 2
//   valid = size > 0
//   data  = front
//   occupancy = size
// Inputs are driven and outputs are sampled on the falling edge. The model
// advances on the rising edge using its own ready/valid view.
// -----------------------------------------------------------------------------
module tb_handshake_skid_buffer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid_pre_i;
    logic [W-1:0] data_pre_i;
    logic         ready_pre_o;
    logic         valid_post_o;
    logic [W-1:0] data_post_o;
    logic         ready_post_i;
    logic [1:0]   occupancy_o;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] mq[$];

    handshake_skid_buffer #(.DATA_W(W)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_pre_i  (valid_pre_i),
        .data_pre_i   (data_pre_i),
        .ready_pre_o  (ready_pre_o),
        .valid_post_o (valid_post_o),
        .data_post_o  (data_post_o),
        .ready_post_i (ready_post_i),
        .occupancy_o  (occupancy_o)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model across the rising edge,
    // and return on the following falling edge.
    task automatic cycle(input logic v, input logic [W-1:0] d,
                         input logic r, input logic rs);
        bit ing;
        bit egr;
        valid_pre_i  = v;
        data_pre_i   = d;
        ready_post_i = r;
        rst          = rs;
        ing = v && (mq.size() < 2);
        egr = r && (mq.size() > 0);
        @(posedge clk);
        if (rs) begin
            mq.delete();
        end else begin
            if (egr) void'(mq.pop_front());
            if (ing) mq.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        total++; if (ready_pre_o !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", ready_pre_o); end
        total++; if (valid_post_o !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid_post_o); end
        total++; if (data_post_o !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", data_post_o); end
        total++; if (occupancy_o !== 2'd0) begin bad++; $display("FAIL reset_occ: got %0d want 0", occupancy_o); end
    endtask

    task automatic test_single_word();
        // First edge after reset release must accept.
        cycle(1'b1, 8'hA5, 1'b1, 1'b0);
        total++; if (valid_post_o !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", valid_post_o); end
        total++; if (data_post_o !== 8'hA5) begin bad++; $display("FAIL single_data: got %h want a5", data_post_o); end
        total++; if (occupancy_o !== 2'd1) begin bad++; $display("FAIL single_occ: got %0d want 1", occupancy_o); end
        cycle(1'b0, 8'h5A, 1'b1, 1'b0);
        total++; if (occupancy_o !== 2'd0) begin bad++; $display("FAIL single_occ_after: got %0d want 0", occupancy_o); end
        total++; if (valid_post_o !== 1'b0) begin bad++; $display("FAIL single_valid_after: got %b want 0", valid_post_o); end
    endtask

    task automatic test_streaming();
        for (int i = 0; i <= 16; i++) begin
            total++;
            if (ready_pre_o !== 1'b1) begin
                bad++; $display("FAIL stream_ready[%0d]: got %b want 1", i, ready_pre_o);
            end
            if (i > 0) begin
                total++;
                if (valid_post_o !== 1'b1 || data_post_o !== 8'(i - 1)) begin
                    bad++;
                    $display("FAIL stream_egress[%0d]: got v=%b d=%h want v=1 d=%h",
                             i, valid_post_o, data_post_o, 8'(i - 1));
                end
            end
            cycle(i < 16, 8'(i), 1'b1, 1'b0);
        end
        total++; if (occupancy_o !== 2'd0) begin bad++; $display("FAIL stream_occ_end: got %0d want 0", occupancy_o); end
    endtask

    task automatic test_backpressure_drain();
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        total++; if (ready_pre_o !== 1'b1 || occupancy_o !== 2'd1) begin bad++; $display("FAIL bp_after1: got rdy=%b occ=%0d want rdy=1 occ=1", ready_pre_o, occupancy_o); end
        cycle(1'b1, 8'h22, 1'b0, 1'b0);
        total++; if (ready_pre_o !== 1'b0) begin bad++; $display("FAIL bp_ready_third: got %b want 0", ready_pre_o); end
        total++; if (occupancy_o !== 2'd2) begin bad++; $display("FAIL bp_occ_full: got %0d want 2", occupancy_o); end
        total++; if (data_post_o !== 8'h11 || valid_post_o !== 1'b1) begin bad++; $display("FAIL bp_hold: got v=%b d=%h want v=1 d=11", valid_post_o, data_post_o); end
        // 0x33 is offered while full and must be refused.
        cycle(1'b1, 8'h33, 1'b0, 1'b0);
        total++; if (occupancy_o !== 2'd2 || data_post_o !== 8'h11 || ready_pre_o !== 1'b0) begin bad++; $display("FAIL bp_stall: got occ=%0d d=%h rdy=%b want occ=2 d=11 rdy=0", occupancy_o, data_post_o, ready_pre_o); end
        // Drain: egress 0x11.
        cycle(1'b1, 8'h33, 1'b1, 1'b0);
        total++; if (ready_pre_o !== 1'b1) begin bad++; $display("FAIL drain_ready: got %b want 1", ready_pre_o); end
        total++; if (valid_post_o !== 1'b1 || data_post_o !== 8'h22) begin bad++; $display("FAIL drain_second: got v=%b d=%h want v=1 d=22", valid_post_o, data_post_o); end
        // Egress 0x22, 0x33 accepted in the same cycle.
        cycle(1'b1, 8'h33, 1'b1, 1'b0);
        total++; if (valid_post_o !== 1'b1 || data_post_o !== 8'h33) begin bad++; $display("FAIL drain_third: got v=%b d=%h want v=1 d=33", valid_post_o, data_post_o); end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if (occupancy_o !== 2'd0 || valid_post_o !== 1'b0) begin bad++; $display("FAIL drain_empty: got occ=%0d v=%b want occ=0 v=0", occupancy_o, valid_post_o); end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 8'h44, 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b0, 1'b0);
        total++; if (occupancy_o !== 2'd2) begin bad++; $display("FAIL rmid_full: got %0d want 2", occupancy_o); end
        cycle(1'b1, 8'h66, 1'b1, 1'b1);
        total++; if (valid_post_o !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", valid_post_o); end
        total++; if (data_post_o !== 8'h00) begin bad++; $display("FAIL rmid_data: got %h want 00", data_post_o); end
        total++; if (occupancy_o !== 2'd0 || ready_pre_o !== 1'b1) begin bad++; $display("FAIL rmid_state: got occ=%0d rdy=%b want occ=0 rdy=1", occupancy_o, ready_pre_o); end
        // Reset while BUSY with a word offered: the word must not be taken.
        cycle(1'b1, 8'h77, 1'b0, 1'b0);
        cycle(1'b1, 8'h88, 1'b0, 1'b1);
        total++; if (occupancy_o !== 2'd0 || valid_post_o !== 1'b0) begin bad++; $display("FAIL rmid_busy_rst: got occ=%0d v=%b want occ=0 v=0", occupancy_o, valid_post_o); end
        // First edge after release accepts.
        cycle(1'b1, 8'h99, 1'b0, 1'b0);
        total++; if (occupancy_o !== 2'd1 || data_post_o !== 8'h99) begin bad++; $display("FAIL rmid_first_accept: got occ=%0d d=%h want occ=1 d=99", occupancy_o, data_post_o); end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        total++; if (occupancy_o !== 2'd0) begin bad++; $display("FAIL rmid_drain: got %0d want 0", occupancy_o); end
    endtask

    task automatic test_random();
        int           pv;
        int           pr;
        bit           v;
        bit           r;
        logic [W-1:0] d;
        bit           stalled = 1'b0;
        logic [W-1:0] held    = '0;
        for (int n = 0; n < 10000; n++) begin
            if (n % 500 == 0) begin
                pv = int'($urandom_range(10, 95));
                pr = int'($urandom_range(10, 95));
            end
            total++;
            if (occupancy_o !== 2'(mq.size())) begin
                bad++; $display("FAIL rand_occ@%0d: got %0d want %0d", n, occupancy_o, mq.size());
            end
            total++;
            if (ready_pre_o !== (mq.size() < 2) || valid_post_o !== (mq.size() > 0)) begin
                bad++; $display("FAIL rand_flags@%0d: got rdy=%b v=%b want rdy=%b v=%b",
                                n, ready_pre_o, valid_post_o, mq.size() < 2, mq.size() > 0);
            end
            if (mq.size() > 0) begin
                total++;
                if (data_post_o !== mq[0]) begin
                    bad++; $display("FAIL rand_data@%0d: got %h want %h", n, data_post_o, mq[0]);
                end
            end
            if (stalled) begin
                total++;
                if (valid_post_o !== 1'b1 || data_post_o !== held) begin
                    bad++; $display("FAIL rand_stable@%0d: got v=%b d=%h want v=1 d=%h",
                                    n, valid_post_o, data_post_o, held);
                end
            end
            v = ($urandom_range(0, 99) < pv);
            r = ($urandom_range(0, 99) < pr);
            d = W'($urandom);
            stalled = (mq.size() > 0) && !r;
            if (stalled) held = mq[0];
            cycle(v, d, r, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            if (mq.size() > 0) begin
                total++;
                if (data_post_o !== mq[0]) begin
                    bad++; $display("FAIL rand_drain_data: got %h want %h", data_post_o, mq[0]);
                end
            end
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        total++;
        if (occupancy_o !== 2'd0 || valid_post_o !== 1'b0) begin
            bad++; $display("FAIL rand_final_empty: got occ=%0d v=%b want occ=0 v=0", occupancy_o, valid_post_o);
        end
    endtask

    initial begin
        rst          = 1'b1;
        valid_pre_i  = 1'b0;
        data_pre_i   = '0;
        ready_post_i = 1'b0;
        test_reset();
        test_single_word();
        test_streaming();
        test_backpressure_drain();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded time limit, got timeout want completion");
        $fatal(1, "simulation timeout");
    end

endmodule : tb_handshake_skid_buffer
